// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state and mode definitions for led_match_status
package led_pkg;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_MATCH   = 2'd1,
        S_MISS    = 2'd2,
        S_LATCHED = 2'd3
    } state_e;

    localparam logic [1:0] MODE_LIVE   = 2'd0;
    localparam logic [1:0] MODE_STICKY = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;

    function automatic logic state_green(input state_e s);
        return (s == S_MATCH) || (s == S_LATCHED);
    endfunction

endpackage

// File: rtl/led_stable_qual.sv
// rtl/led_stable_qual.sv - compare against match value and qualify after a stable run
module led_stable_qual #(
    parameter int                DATA_W        = 4,
    parameter logic [DATA_W-1:0] MATCH_VAL     = {DATA_W{1'b1}},
    parameter int                STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] led_in,
    input  logic              in_valid,
    input  logic              clear,
    output logic              q,
    output logic              q_vld
);

    localparam int             RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic             cmp;
    logic [RUN_W-1:0] run_q, run_d;
    logic             prev_q, prev_d;
    logic             q_q, q_d;
    logic             strobe;

    assign cmp = (led_in == MATCH_VAL);

    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        strobe = 1'b0;
        if (clear || !in_valid) begin
            run_d = '0;
        end else begin
            prev_d = cmp;
            if ((run_q == '0) || (cmp != prev_q)) begin
                run_d = RUN_W'(1);
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            // A saturated run with an unchanged result must not re-strobe.
            strobe = (run_d == RUN_MAX) && !((run_q == RUN_MAX) && (cmp == prev_q));
        end
        q_d = strobe ? cmp : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
            q_q    <= q_d;
        end
    end

    assign q     = q_d;
    assign q_vld = strobe;

endmodule

// File: rtl/led_match_status.sv
// rtl/led_match_status.sv - qualified match indicator with live/sticky/blink LEDs and event counter
module led_match_status
    import led_pkg::*;
#(
    parameter int                DATA_W        = 4,
    parameter logic [DATA_W-1:0] MATCH_VAL     = {DATA_W{1'b1}},
    parameter int                STABLE_CYCLES = 4,
    parameter int                BLINK_HALF    = 8,
    parameter int                CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] led_in,
    input  logic              in_valid,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic              led_green,
    output logic              led_red,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int                 BLINK_W    = $clog2(2 * BLINK_HALF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ON   = BLINK_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    logic               q;
    logic               q_vld;
    state_e             state_q, state_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               green_q, green_d;
    logic               red_q, red_d;
    logic [1:0]         mode_q;
    logic               blink_reload;

    led_stable_qual #(
        .DATA_W        (DATA_W),
        .MATCH_VAL     (MATCH_VAL),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_qual (
        .clk      (clk),
        .rst      (rst),
        .led_in   (led_in),
        .in_valid (in_valid),
        .clear    (clear),
        .q        (q),
        .q_vld    (q_vld)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_INIT;
        end else if (in_valid) begin
            case (state_q)
                S_INIT:    if (q_vld) state_d = q ? S_MATCH : S_MISS;
                S_MATCH:   if (q_vld && !q) state_d = (mode == MODE_STICKY) ? S_LATCHED : S_MISS;
                S_MISS:    if (q_vld && q) state_d = S_MATCH;
                S_LATCHED: if (mode != MODE_STICKY) state_d = q ? S_MATCH : S_MISS;
                default:   state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        blink_d      = blink_q;
        blink_reload = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if ((state_d == S_MATCH) && ((state_q == S_INIT) || (state_q == S_MISS))
                     && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Restart the blink phase with red on whenever blinking becomes visible afresh.
        blink_reload = (state_d == S_MISS) &&
                       ((state_q != S_MISS) || ((mode == MODE_BLINK) && (mode_q != MODE_BLINK)));
        if (blink_reload) begin
            blink_d = '0;
        end else if (state_d == S_MISS) begin
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
        end

        green_d = state_green(state_d);
        red_d   = (state_d == S_MISS) && ((mode != MODE_BLINK) || (blink_d < BLINK_ON));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            blink_q <= '0;
            cnt_q   <= '0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            mode_q  <= MODE_LIVE;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
            green_q <= green_d;
            red_q   <= red_d;
            mode_q  <= mode;
        end
    end

    assign led_green = green_q;
    assign led_red   = red_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_led_match_status.sv
// tb/tb_led_match_status.sv - scoreboard bench for led_match_status against a behavioural model
module tb_led_match_status;

    localparam int         DATA_W    = 4;
    localparam logic [3:0] MATCH_VAL = 4'hF;
    localparam int         S         = 4;
    localparam int         BH        = 8;
    localparam int         CNT_W     = 2;
    localparam int         CNT_MAX   = (1 << CNT_W) - 1;

    localparam int M_INIT = 0, M_MATCH = 1, M_MISS = 2, M_LATCHED = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] led_in;
    logic              in_valid;
    logic [1:0]        mode;
    logic              clear;
    logic              led_green;
    logic              led_red;
    logic [CNT_W-1:0]  match_cnt;

    always #5 clk = ~clk;

    led_match_status #(
        .DATA_W        (DATA_W),
        .MATCH_VAL     (MATCH_VAL),
        .STABLE_CYCLES (S),
        .BLINK_HALF    (BH),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .in_valid  (in_valid),
        .mode      (mode),
        .clear     (clear),
        .led_green (led_green),
        .led_red   (led_red),
        .match_cnt (match_cnt)
    );

    typedef struct { logic g; logic r; int c; int cyc; } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_pass = 0, cyc = 0;

    int m_state = M_INIT, m_cnt = 0, m_age = 0, m_prev_mode = 0;
    bit m_q = 0, m_g = 0, m_r = 0;
    bit hist[$];

    function automatic void check(input string name, input int act, input int exp, input int at);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, at, act, exp);
    endfunction

    // Reference: a qualifying event is the edge where the trailing run of identical
    // valid compare results (since the last gap/clear) becomes exactly S long.
    function automatic void model_edge();
        bit cmp;
        bit qv;
        int run;
        int ns;
        if (rst) begin
            hist.delete();
            m_state = M_INIT; m_cnt = 0; m_age = 0; m_prev_mode = 0;
            m_q = 0; m_g = 0; m_r = 0;
            return;
        end
        cmp = (led_in == MATCH_VAL);
        qv  = 0;
        if (clear || !in_valid) begin
            hist.delete();
        end else begin
            hist.push_back(cmp);
            if (hist.size() > S + 1) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] == cmp) run++;
                else break;
            end
            if (run == S) begin
                qv  = 1;
                m_q = cmp;
            end
        end
        ns = m_state;
        if (clear) ns = M_INIT;
        else if (in_valid) begin
            case (m_state)
                M_INIT:    if (qv) ns = m_q ? M_MATCH : M_MISS;
                M_MATCH:   if (qv && !m_q) ns = (mode == 2'd1) ? M_LATCHED : M_MISS;
                M_MISS:    if (qv && m_q) ns = M_MATCH;
                default:   if (mode != 2'd1) ns = m_q ? M_MATCH : M_MISS;
            endcase
        end
        if (clear) m_cnt = 0;
        else if (ns == M_MATCH && (m_state == M_INIT || m_state == M_MISS) && m_cnt < CNT_MAX) m_cnt++;
        if (ns == M_MISS && (m_state != M_MISS || (mode == 2'd2 && m_prev_mode != 2))) m_age = 0;
        else if (ns == M_MISS) m_age++;
        m_prev_mode = int'(mode);
        m_state = ns;
        m_g = (ns == M_MATCH) || (ns == M_LATCHED);
        m_r = (ns == M_MISS) && ((mode != 2'd2) || ((m_age / BH) % 2 == 0));
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input logic [3:0] d, input logic [1:0] m);
        rst = r; clear = c; in_valid = v; led_in = d; mode = m;
        @(posedge clk);
        model_edge();
        cyc++;
        sbq.push_back('{g: m_g, r: m_r, c: m_cnt, cyc: cyc});
        #1;
    endtask

    task automatic hold(input int n, input logic [3:0] d, input logic [1:0] m);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, d, m);
    endtask

    task automatic expect_now(input string name, input bit g, input bit r, input int c);
        check({name, "_green"}, int'(led_green), int'(g), cyc);
        check({name, "_red"}, int'(led_red), int'(r), cyc);
        check({name, "_cnt"}, int'(match_cnt), c, cyc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_led_green", int'(led_green), int'(e.g), e.cyc);
                check("sb_led_red", int'(led_red), int'(e.r), e.cyc);
                check("sb_match_cnt", int'(match_cnt), e.c, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not reach summary, cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [3:0] cur;
        logic [1:0] m;
        step(1, 0, 0, 4'h0, 2'd0);
        step(1, 0, 0, 4'h0, 2'd0);
        expect_now("reset", 0, 0, 0);

        hold(3, 4'hF, 2'd0);
        expect_now("settle", 0, 0, 0);
        hold(1, 4'hF, 2'd0);
        expect_now("first_match", 1, 0, 1);

        hold(3, 4'h7, 2'd0);
        hold(4, 4'hF, 2'd0);
        expect_now("glitch", 1, 0, 1);
        hold(3, 4'h7, 2'd0);
        expect_now("miss_pending", 1, 0, 1);
        hold(1, 4'h7, 2'd0);
        expect_now("miss", 0, 1, 1);

        hold(4, 4'hF, 2'd1);
        expect_now("sticky_match", 1, 0, 2);
        hold(10, 4'h0, 2'd1);
        expect_now("sticky_hold", 1, 0, 2);
        step(0, 1, 1, 4'h0, 2'd1);
        expect_now("clear", 0, 0, 0);

        hold(4, 4'h3, 2'd2);
        expect_now("blink_on", 0, 1, 0);
        for (int i = 1; i < 24; i++) begin
            hold(1, 4'h3, 2'd2);
            check("blink_phase_red", int'(led_red), ((i / 8) % 2 == 0) ? 1 : 0, cyc);
            check("blink_phase_green", int'(led_green), 0, cyc);
        end

        for (int i = 0; i < 5; i++) begin
            hold(4, 4'hF, 2'd0);
            hold(4, 4'h0, 2'd0);
        end
        expect_now("saturate", 0, 1, 3);

        hold(3, 4'hF, 2'd0);
        step(0, 1, 1, 4'hF, 2'd0);
        expect_now("clear_vs_qual", 0, 0, 0);
        hold(3, 4'hF, 2'd0);
        expect_now("after_clear_run", 0, 0, 0);
        hold(1, 4'hF, 2'd0);
        expect_now("after_clear_match", 1, 0, 1);

        hold(4, 4'h3, 2'd2);
        hold(5, 4'h3, 2'd2);
        step(1, 0, 1, 4'h3, 2'd2);
        expect_now("reset_mid", 0, 0, 0);
        hold(3, 4'hF, 2'd0);
        expect_now("reset_resettle", 0, 0, 0);
        hold(1, 4'hF, 2'd0);
        expect_now("reset_match", 1, 0, 1);

        cur = 4'hF;
        m   = 2'd0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) < 2) cur = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 29) == 0) m = 2'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) < 90, cur, m);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drain", sbq.size(), 0, cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
